// File: rtl/regfile_pkg.sv
// Shared register-file geometry and write-queue defaults.
package regfile_pkg;
    localparam int RF_ADDR_WIDTH    = 5;
    localparam int RF_DATA_WIDTH    = 32;
    localparam int RF_ZERO_REG      = 0;
    localparam int WQ_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/regfile_write_queue_if.sv
// Producer handshakes, decode hazard lookup and RF write port of the write queue.
// Fwd1Data/Fwd2Data exist only when REGFILE_WQ_BYPASS_EN is defined.
interface regfile_write_queue_if #(
    parameter int DEPTH      = regfile_pkg::WQ_DEPTH_DEFAULT,
    parameter int DATA_WIDTH = regfile_pkg::RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::RF_ADDR_WIDTH
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  AluValid;
    logic [ADDR_WIDTH-1:0] AluReg;
    logic [DATA_WIDTH-1:0] AluData;
    logic                  AluReady;
    logic                  LoadValid;
    logic [ADDR_WIDTH-1:0] LoadReg;
    logic [DATA_WIDTH-1:0] LoadData;
    logic                  LoadReady;
    logic [ADDR_WIDTH-1:0] ReadRegister1;
    logic [ADDR_WIDTH-1:0] ReadRegister2;
    logic                  Hazard1;
    logic                  Hazard2;
    logic [ADDR_WIDTH-1:0] WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  RegWrite;
    logic [CW-1:0]         Count;
`ifdef REGFILE_WQ_BYPASS_EN
    logic [DATA_WIDTH-1:0] Fwd1Data;
    logic [DATA_WIDTH-1:0] Fwd2Data;
`endif

    modport slave (
        input  AluValid, AluReg, AluData, LoadValid, LoadReg, LoadData,
        input  ReadRegister1, ReadRegister2,
        output AluReady, LoadReady, Hazard1, Hazard2,
        output WriteRegister, WriteData, RegWrite, Count
`ifdef REGFILE_WQ_BYPASS_EN
        , output Fwd1Data, Fwd2Data
`endif
    );

    modport master (
        output AluValid, AluReg, AluData, LoadValid, LoadReg, LoadData,
        output ReadRegister1, ReadRegister2,
        input  AluReady, LoadReady, Hazard1, Hazard2,
        input  WriteRegister, WriteData, RegWrite, Count
`ifdef REGFILE_WQ_BYPASS_EN
        , input Fwd1Data, Fwd2Data
`endif
    );
endinterface

// File: rtl/regfile_write_queue_wq_fifo.sv
// Two-write/one-read circular buffer; entry views are presented oldest-first.
// ent_data_o exists only when REGFILE_WQ_BYPASS_EN is defined.
module wq_fifo #(
    parameter int DEPTH      = regfile_pkg::WQ_DEPTH_DEFAULT,
    parameter int DATA_WIDTH = regfile_pkg::RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::RF_ADDR_WIDTH,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr0_en_i,
    input  logic [ADDR_WIDTH-1:0] wr0_reg_i,
    input  logic [DATA_WIDTH-1:0] wr0_data_i,
    input  logic                  wr1_en_i,
    input  logic [ADDR_WIDTH-1:0] wr1_reg_i,
    input  logic [DATA_WIDTH-1:0] wr1_data_i,
    input  logic                  rd_en_i,
    output logic [CW-1:0]         count_o,
    output logic [ADDR_WIDTH-1:0] head_reg_o,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic [DEPTH-1:0]      ent_valid_o,
    output logic [ADDR_WIDTH-1:0] ent_reg_o [DEPTH]
`ifdef REGFILE_WQ_BYPASS_EN
    , output logic [DATA_WIDTH-1:0] ent_data_o [DEPTH]
`endif
);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0] reg_mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  rd_fire;

    assign rd_fire  = rd_en_i && (count_q != '0);
    assign wr_ptr_d = wr_ptr_q + PW'(wr0_en_i) + PW'(wr1_en_i);
    assign rd_ptr_d = rd_ptr_q + PW'(rd_fire);
    assign count_d  = count_q + CW'(wr0_en_i) + CW'(wr1_en_i) - CW'(rd_fire);

    // NOTE: state registers use <= so every flop samples pre-edge values in parallel.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only observed once count_q covers it.
    always_ff @(posedge clk) begin
        if (wr0_en_i) begin
            reg_mem_q[wr_ptr_q]  <= wr0_reg_i;
            data_mem_q[wr_ptr_q] <= wr0_data_i;
        end
        if (wr1_en_i) begin
            reg_mem_q[wr_ptr_q + PW'(1)]  <= wr1_reg_i;
            data_mem_q[wr_ptr_q + PW'(1)] <= wr1_data_i;
        end
    end

    assign count_o     = count_q;
    assign head_reg_o  = reg_mem_q[rd_ptr_q];
    assign head_data_o = data_mem_q[rd_ptr_q];

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [PW-1:0] idx;
        assign idx            = rd_ptr_q + PW'(g);
        assign ent_valid_o[g] = CW'(g) < count_q;
        assign ent_reg_o[g]   = reg_mem_q[idx];
`ifdef REGFILE_WQ_BYPASS_EN
        assign ent_data_o[g]  = data_mem_q[idx];
`endif
    end
endmodule

// File: rtl/regfile_write_queue.sv
// Write-back queue merging ALU and load results into the single RF write port.
// REGFILE_WQ_BYPASS_EN adds forwarding of the youngest pending write to decode.
module regfile_write_queue #(
    parameter int DEPTH      = regfile_pkg::WQ_DEPTH_DEFAULT,
    parameter int DATA_WIDTH = regfile_pkg::RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::RF_ADDR_WIDTH
) (
    input logic                  Clk,
    input logic                  Reset,
    regfile_write_queue_if.slave wq
);
    import regfile_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = ADDR_WIDTH'(RF_ZERO_REG);

    logic [CW-1:0]         count, free;
    logic                  load_enq, alu_enq;
    logic                  first_en, second_en, fall_through;
    logic [ADDR_WIDTH-1:0] first_reg, head_reg;
    logic [DATA_WIDTH-1:0] first_data, head_data;
    logic                  fifo_wr0_en, fifo_wr1_en;
    logic [ADDR_WIDTH-1:0] fifo_wr0_reg;
    logic [DATA_WIDTH-1:0] fifo_wr0_data;
    logic [DEPTH-1:0]      ent_valid;
    logic [ADDR_WIDTH-1:0] ent_reg [DEPTH];
    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0] out_reg_q, out_reg_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    // Space is judged on the registered count alone; a same-cycle dequeue never helps.
    assign free         = CW'(DEPTH) - count;
    assign wq.LoadReady = free >= CW'(1);
    assign wq.AluReady  = wq.LoadValid ? (free >= CW'(2)) : (free >= CW'(1));
    assign load_enq     = wq.LoadValid && wq.LoadReady && (wq.LoadReg != ZERO_REG);
    assign alu_enq      = wq.AluValid && wq.AluReady && (wq.AluReg != ZERO_REG);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        first_en      = load_enq || alu_enq;
        second_en     = load_enq && alu_enq;
        first_reg     = load_enq ? wq.LoadReg  : wq.AluReg;
        first_data    = load_enq ? wq.LoadData : wq.AluData;
        fall_through  = (count == '0) && first_en;
        fifo_wr0_en   = fall_through ? second_en : first_en;
        fifo_wr0_reg  = fall_through ? wq.AluReg  : first_reg;
        fifo_wr0_data = fall_through ? wq.AluData : first_data;
        fifo_wr1_en   = fall_through ? 1'b0 : second_en;

        out_valid_d = 1'b0;
        out_reg_d   = out_reg_q;
        out_data_d  = out_data_q;
        if (count != '0) begin
            out_valid_d = 1'b1;
            out_reg_d   = head_reg;
            out_data_d  = head_data;
        end else if (first_en) begin
            out_valid_d = 1'b1;
            out_reg_d   = first_reg;
            out_data_d  = first_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            out_reg_q   <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_reg_q   <= out_reg_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef REGFILE_WQ_BYPASS_EN
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];
    logic [DATA_WIDTH-1:0] fwd1, fwd2;
`endif

    wq_fifo #(
        .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fifo (
        .clk        (Clk),
        .rst        (Reset),
        .wr0_en_i   (fifo_wr0_en),
        .wr0_reg_i  (fifo_wr0_reg),
        .wr0_data_i (fifo_wr0_data),
        .wr1_en_i   (fifo_wr1_en),
        .wr1_reg_i  (wq.AluReg),
        .wr1_data_i (wq.AluData),
        .rd_en_i    (count != '0),
        .count_o    (count),
        .head_reg_o (head_reg),
        .head_data_o(head_data),
        .ent_valid_o(ent_valid),
        .ent_reg_o  (ent_reg)
`ifdef REGFILE_WQ_BYPASS_EN
        , .ent_data_o(ent_data)
`endif
    );

    assign wq.WriteRegister = out_reg_q;
    assign wq.WriteData     = out_data_q;
    assign wq.RegWrite      = out_valid_q;
    assign wq.Count         = count;

`ifdef REGFILE_WQ_BYPASS_EN
    // Oldest first, so the youngest match is the one left standing.
    always_comb begin
        fwd1 = (out_valid_q && (out_reg_q == wq.ReadRegister1)) ? out_data_q : '0;
        fwd2 = (out_valid_q && (out_reg_q == wq.ReadRegister2)) ? out_data_q : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_reg[i] == wq.ReadRegister1)) fwd1 = ent_data[i];
            if (ent_valid[i] && (ent_reg[i] == wq.ReadRegister2)) fwd2 = ent_data[i];
        end
    end

    assign wq.Fwd1Data = fwd1;
    assign wq.Fwd2Data = fwd2;
    assign wq.Hazard1  = 1'b0;
    assign wq.Hazard2  = 1'b0;
`else
    logic hit1, hit2;

    always_comb begin
        hit1 = out_valid_q && (out_reg_q == wq.ReadRegister1);
        hit2 = out_valid_q && (out_reg_q == wq.ReadRegister2);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_reg[i] == wq.ReadRegister1)) hit1 = 1'b1;
            if (ent_valid[i] && (ent_reg[i] == wq.ReadRegister2)) hit2 = 1'b1;
        end
    end

    assign wq.Hazard1 = hit1 && (wq.ReadRegister1 != ZERO_REG);
    assign wq.Hazard2 = hit2 && (wq.ReadRegister2 != ZERO_REG);
`endif
endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: scoreboard of expected RF writes plus
// inline checks of handshake, count and hazard/forwarding outputs.
module tb_regfile_write_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
`ifdef REGFILE_WQ_BYPASS_EN
    localparam logic HZ = 1'b0;
`else
    localparam logic HZ = 1'b1;
`endif

    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } wr_t;

    logic Clk = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;
    wr_t  exp_q [$];
    logic [DW-1:0] rf [32];

    always #5 Clk = ~Clk;

    regfile_write_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wq ();

    regfile_write_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .wq   (wq)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RF side: every RegWrite seen must be the next expected write.
    always @(negedge Clk) begin : monitor
        wr_t e;
        if (wq.RegWrite !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {63'd0, wq.RegWrite}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_reg", {59'd0, wq.WriteRegister}, {59'd0, e.r});
                check("wr_data", {32'd0, wq.WriteData}, {32'd0, e.d});
                rf[wq.WriteRegister] = wq.WriteData;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic mid();
        @(negedge Clk);
    endtask

    task automatic idle();
        wq.AluValid  = 1'b0;
        wq.LoadValid = 1'b0;
    endtask

    task automatic drive_load(input logic [AW-1:0] r, input logic [DW-1:0] d);
        wq.LoadValid = 1'b1;
        wq.LoadReg   = r;
        wq.LoadData  = d;
    endtask

    task automatic drive_alu(input logic [AW-1:0] r, input logic [DW-1:0] d);
        wq.AluValid = 1'b1;
        wq.AluReg   = r;
        wq.AluData  = d;
    endtask

    task automatic expect_write(input logic [AW-1:0] r, input logic [DW-1:0] d);
        exp_q.push_back(wr_t'{r: r, d: d});
    endtask

    // Waits (bounded) for queue and output register to empty.
    task automatic drain(input string tag);
        int n = 0;
        mid();
        while (!(wq.Count == '0 && wq.RegWrite == 1'b0) && n < 20) begin
            cyc();
            mid();
            n++;
        end
        check({tag, "_drained"}, {63'd0, (wq.Count == '0 && wq.RegWrite == 1'b0)}, 64'd1);
        check({tag, "_sb_empty"}, exp_q.size(), 64'd0);
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        Reset = 1'b1;
        idle();
        wq.AluReg = '0;  wq.AluData = '0;
        wq.LoadReg = '0; wq.LoadData = '0;
        wq.ReadRegister1 = '0;
        wq.ReadRegister2 = '0;
        cyc();
        cyc();
        Reset = 1'b0;

        // Reset state
        mid();
        check("rst_count", wq.Count, 0);
        check("rst_regwrite", wq.RegWrite, 0);
        check("rst_wreg", wq.WriteRegister, 0);
        check("rst_wdata", wq.WriteData, 0);
        check("rst_load_ready", wq.LoadReady, 1);
        check("rst_alu_ready", wq.AluReady, 1);
        cyc();

        // Single write: visible on the RF port the cycle after acceptance
        drive_alu(5'd16, 32'hDEAD_DAD5);
        wq.ReadRegister1 = 5'd16;
        mid();
        check("single_alu_ready", wq.AluReady, 1);
        check("single_hz_same_cycle", wq.Hazard1, 0);
        expect_write(5'd16, 32'hDEAD_DAD5);
        cyc();
        idle();
        mid();
        check("single_regwrite", wq.RegWrite, 1);
        check("single_count", wq.Count, 0);
        check("single_hz_inflight", wq.Hazard1, HZ);
        cyc();
        mid();
        check("single_regwrite_off", wq.RegWrite, 0);
        check("single_hz_after", wq.Hazard1, 0);
        check("single_wreg_hold", wq.WriteRegister, 16);
        check("single_wdata_hold", wq.WriteData, 32'hDEAD_DAD5);
        cyc();

        // Dual accept to the same register: load is older
        drive_load(5'd3, 32'h0000_0001);
        drive_alu(5'd3, 32'h0000_0002);
        wq.ReadRegister1 = 5'd5;
        wq.ReadRegister2 = 5'd3;
        mid();
        check("dual_load_ready", wq.LoadReady, 1);
        check("dual_alu_ready", wq.AluReady, 1);
        expect_write(5'd3, 32'h0000_0001);
        expect_write(5'd3, 32'h0000_0002);
        cyc();
        idle();
        mid();
        check("dual_count", wq.Count, 1);
        check("dual_first_data", wq.WriteData, 32'h0000_0001);
        check("dual_hz2_queued", wq.Hazard2, HZ);
        check("dual_hz1_other", wq.Hazard1, 0);
        cyc();
        mid();
        check("dual_second_regwrite", wq.RegWrite, 1);
        check("dual_second_data", wq.WriteData, 32'h0000_0002);
        check("dual_count_empty", wq.Count, 0);
        cyc();
        drain("dual");
        check("dual_rf_r3", rf[3], 32'h0000_0002);

        // Fill with back-to-back dual accepts until only one slot is free
        for (int k = 0; k < 3; k++) begin
            drive_load(AW'(4 + k), DW'(32'h100 + k));
            drive_alu(AW'(8 + k), DW'(32'h200 + k));
            mid();
            check("fill_count", wq.Count, k);
            check("fill_load_ready", wq.LoadReady, 1);
            check("fill_alu_ready", wq.AluReady, 1);
            expect_write(AW'(4 + k), DW'(32'h100 + k));
            expect_write(AW'(8 + k), DW'(32'h200 + k));
            cyc();
        end
        drive_load(5'd7, 32'h103);
        drive_alu(5'd11, 32'h203);
        wq.ReadRegister1 = 5'd10;
        wq.ReadRegister2 = 5'd15;
        mid();
        check("full_count", wq.Count, 3);
        check("full_load_ready", wq.LoadReady, 1);
        check("full_alu_stalled", wq.AluReady, 0);
        check("full_hz1_queued", wq.Hazard1, HZ);
        check("full_hz2_none", wq.Hazard2, 0);
        expect_write(5'd7, 32'h103);
        cyc();
        wq.LoadValid = 1'b0;
        mid();
        check("full_alu_ready_noload", wq.AluReady, 1);
        check("full_count_steady", wq.Count, 3);
        expect_write(5'd11, 32'h203);
        cyc();
        idle();
        drain("full");

        // Register 0: handshake completes, nothing is written
        drive_alu(5'd0, 32'hFFFF_FFFF);
        wq.ReadRegister1 = 5'd0;
        mid();
        check("zero_alu_ready", wq.AluReady, 1);
        check("zero_hz1", wq.Hazard1, 0);
        cyc();
        idle();
        mid();
        check("zero_count", wq.Count, 0);
        check("zero_regwrite", wq.RegWrite, 0);
        cyc();
        mid();
        check("zero_regwrite_late", wq.RegWrite, 0);
        cyc();

        // Reset while three entries are queued
        for (int k = 0; k < 3; k++) begin
            drive_load(AW'(20 + k), DW'(32'h300 + k));
            drive_alu(AW'(24 + k), DW'(32'h400 + k));
            expect_write(AW'(20 + k), DW'(32'h300 + k));
            expect_write(AW'(24 + k), DW'(32'h400 + k));
            cyc();
        end
        idle();
        Reset = 1'b1;
        mid();
        check("mrst_count_before", wq.Count, 3);
        cyc();
        Reset = 1'b0;
        exp_q.delete();
        mid();
        check("mrst_count", wq.Count, 0);
        check("mrst_regwrite", wq.RegWrite, 0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            mid();
            check("mrst_no_write", wq.RegWrite, 0);
        end
        cyc();

        // Two pending writes to r31: the younger value is the one to forward
        drive_load(5'd31, 32'hDEAD_BEEF);
        drive_alu(5'd31, 32'h1234_5678);
        expect_write(5'd31, 32'hDEAD_BEEF);
        expect_write(5'd31, 32'h1234_5678);
        wq.ReadRegister1 = 5'd31;
        wq.ReadRegister2 = 5'd31;
        cyc();
        idle();
        mid();
`ifdef REGFILE_WQ_BYPASS_EN
        check("byp_fwd1", wq.Fwd1Data, 32'h1234_5678);
        check("byp_fwd2", wq.Fwd2Data, 32'h1234_5678);
`endif
        check("byp_hz1", wq.Hazard1, HZ);
        check("byp_count", wq.Count, 1);
        cyc();
        drain("byp");
        check("byp_rf_r31", rf[31], 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
